// File: rtl/alu_div_arb.sv
// Round-robin arbiter/sequencer sharing one multi-cycle alu_div between two requesters.
// Define DIV_CACHE_EN to add a one-entry {funct,op1,op2,result} cache that bypasses the divider.
module alu_div_arb #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [4:0]      req0_funct_i,
    input  logic [XLEN-1:0] req0_op1_i,
    input  logic [XLEN-1:0] req0_op2_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [4:0]      req1_funct_i,
    input  logic [XLEN-1:0] req1_op1_i,
    input  logic [XLEN-1:0] req1_op2_i,
    output logic [1:0]      rsp_valid_o,
    input  logic [1:0]      rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_err_o,
    output logic            div_stb_o,
    output logic [4:0]      div_funct_o,
    output logic [XLEN-1:0] div_op1_o,
    output logic [XLEN-1:0] div_op2_o,
    input  logic [XLEN-1:0] div_res_i,
    input  logic            div_done_i,
    output logic            busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic             rr_ptr, owner, grant, accept, timeout, cache_hit;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       sel_funct;
    logic [XLEN-1:0]  sel_op1, sel_op2, cache_res;

    // A lone valid port wins outright; rr_ptr only breaks ties.
    assign grant        = (req0_valid_i && req1_valid_i) ? rr_ptr : req1_valid_i;
    assign accept       = (state_q == S_IDLE) && (req0_valid_i || req1_valid_i) && !Reset;
    assign req0_ready_o = accept && !grant;
    assign req1_ready_o = accept && grant;

    assign sel_funct = grant ? req1_funct_i : req0_funct_i;
    assign sel_op1   = grant ? req1_op1_i   : req0_op1_i;
    assign sel_op2   = grant ? req1_op2_i   : req0_op2_i;

    assign timeout     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign div_stb_o   = (state_q == S_ISSUE);
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP) ? {owner, ~owner} : 2'b00;

`ifdef DIV_CACHE_EN
    logic            cache_valid;
    logic [4:0]      cache_funct;
    logic [XLEN-1:0] cache_op1, cache_op2;

    assign cache_hit = cache_valid && (cache_funct == sel_funct) &&
                       (cache_op1 == sel_op1) && (cache_op2 == sel_op2);

    // Operands are still held on the div_* outputs when the result comes back.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cache_valid <= 1'b0;
            cache_funct <= '0;
            cache_op1   <= '0;
            cache_op2   <= '0;
            cache_res   <= '0;
        end else if (state_q == S_WAIT && div_done_i) begin
            cache_valid <= 1'b1;
            cache_funct <= div_funct_o;
            cache_op1   <= div_op1_o;
            cache_op2   <= div_op2_o;
            cache_res   <= div_res_i;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = cache_hit ? S_RESP : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (div_done_i || timeout) state_d = S_RESP;
            S_RESP:  if (rsp_ready_i[owner]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Done has priority over timeout when both land in the same WAIT cycle.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            cnt_q       <= '0;
            div_funct_o <= '0;
            div_op1_o   <= '0;
            div_op2_o   <= '0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        div_funct_o <= sel_funct;
                        div_op1_o   <= sel_op1;
                        div_op2_o   <= sel_op2;
                        owner       <= grant;
                        rr_ptr      <= ~grant;
                        if (cache_hit) begin
                            rsp_data_o <= cache_res;
                            rsp_err_o  <= 1'b0;
                        end
                    end
                end
                S_ISSUE: cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (div_done_i) begin
                        rsp_data_o <= div_res_i;
                        rsp_err_o  <= 1'b0;
                    end else if (timeout) begin
                        rsp_data_o <= {XLEN{1'b1}};
                        rsp_err_o  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_arb.sv
// Scoreboard bench for alu_div_arb: directed requests, a latency-programmable divider
// model, and a monitor that pops expected responses on every response handshake.
module tb_alu_div_arb;

    logic        clk = 1'b0;
    logic        Reset;
    logic        req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
    logic [4:0]  req0_funct_i, req1_funct_i, div_funct_o;
    logic [31:0] req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
    logic [1:0]  rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_data_o, div_op1_o, div_op2_o, div_res_i;
    logic        rsp_err_o, div_stb_o, div_done_i, busy_o;

`ifdef DIV_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_div_arb dut (
        .clk(clk), .Reset(Reset),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_funct_i(req0_funct_i),
        .req0_op1_i(req0_op1_i), .req0_op2_i(req0_op2_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_funct_i(req1_funct_i),
        .req1_op1_i(req1_op1_i), .req1_op2_i(req1_op2_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_err_o(rsp_err_o), .div_stb_o(div_stb_o), .div_funct_o(div_funct_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_res_i(div_res_i),
        .div_done_i(div_done_i), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;
    int stb_count = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Divider model: done pulses model_latency cycles after the strobe; 0 means never.
    int          model_latency = 0;
    int          model_cnt;
    logic        model_done;
    logic [31:0] model_res;
    logic        extra_done = 1'b0;

    assign div_done_i = model_done | extra_done;
    assign div_res_i  = extra_done ? 32'hDEAD_BEEF : model_res;

    function automatic logic [31:0] divModel(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        if (b == 0)         return 32'hFFFF_FFFF;
        if (f == 5'b10010)  return a / b;
        if (f == 5'b10100)  return a % b;
        return 32'h0;
    endfunction

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            model_cnt  <= 0;
            model_done <= 1'b0;
            model_res  <= '0;
        end else begin
            model_done <= 1'b0;
            if (div_stb_o && model_latency != 0) begin
                model_cnt <= model_latency;
            end else if (model_cnt != 0) begin
                model_cnt <= model_cnt - 1;
                if (model_cnt == 1) begin
                    model_done <= 1'b1;
                    model_res  <= divModel(div_funct_o, div_op1_o, div_op2_o);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pushExpect(input logic [1:0] v, input logic [31:0] d, input logic e);
        exp_t x;
        x.valid = v;
        x.data  = d;
        x.err   = e;
        sb.push_back(x);
    endtask

    // Response monitor: one pop per valid&ready handshake.
    always @(negedge clk) begin
        if (div_stb_o) stb_count++;
        if (!Reset && (rsp_valid_o & rsp_ready_i) != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp actual=%b required=none", rsp_valid_o);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("rsp_valid", {30'd0, rsp_valid_o}, {30'd0, mon_e.valid});
                checkOutput("rsp_data", rsp_data_o, mon_e.data);
                checkOutput("rsp_err", {31'd0, rsp_err_o}, {31'd0, mon_e.err});
            end
        end
    end

    task automatic applyStimulus(input int port, input logic [4:0] funct,
                                 input logic [31:0] op1, input logic [31:0] op2, input bit expect_stb);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (port == 0) begin
            req0_valid_i = 1'b1; req0_funct_i = funct; req0_op1_i = op1; req0_op2_i = op2;
        end else begin
            req1_valid_i = 1'b1; req1_funct_i = funct; req1_op1_i = op1; req1_op2_i = op2;
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((port == 0 && req0_ready_o) || (port == 1 && req1_ready_o)) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        if (port == 0) req0_valid_i = 1'b0;
        else           req1_valid_i = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=no_ready required=ready port=%0d", port);
        end else begin
            @(negedge clk);
            checkOutput("stb_after_accept", {31'd0, div_stb_o}, {31'd0, expect_stb});
            if (!expect_stb)
                checkOutput("rsp_after_accept", {30'd0, rsp_valid_o}, (port == 0) ? 32'd1 : 32'd2);
        end
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_drain actual=%0d_pending required=0", tag, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_ready", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
        checkOutput("rst_rsp_valid", {30'd0, rsp_valid_o}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data_o, 32'd0);
        checkOutput("rst_flags", {29'd0, rsp_err_o, div_stb_o, busy_o}, 32'd0);
        checkOutput("rst_div_ops", div_op1_o | div_op2_o | {27'd0, div_funct_o}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s0, n;
        Reset = 1'b1;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_funct_i = '0; req0_op1_i = '0; req0_op2_i = '0;
        req1_funct_i = '0; req1_op1_i = '0; req1_op2_i = '0;
        rsp_ready_i = 2'b11;
        #1;
        checkResetOutputs();
        repeat (2) @(posedge clk);
        #3 Reset = 1'b0;

        $display("[TB] single request on port 0");
        model_latency = 34;
        s0 = stb_count;
        pushExpect(2'b01, 32'd594, 1'b0);
        applyStimulus(0, 5'b10010, 32'd5946, 32'd10, 1'b1);
        @(negedge clk);
        checkOutput("stb_single_pulse", {31'd0, div_stb_o}, 32'd0);
        waitDrain("t1");
        checkOutput("t1_stb_count", stb_count - s0, 32'd1);

        $display("[TB] repeated request");
        s0 = stb_count;
        pushExpect(2'b01, 32'd594, 1'b0);
        applyStimulus(0, 5'b10010, 32'd5946, 32'd10, !CACHE_ON);
        waitDrain("t6");
        checkOutput("t6_stb_count", stb_count - s0, CACHE_ON ? 32'd0 : 32'd1);

        $display("[TB] round robin from reset");
        @(posedge clk); #2 Reset = 1'b1;
        #1 checkResetOutputs();
        @(posedge clk); #3 Reset = 1'b0;
        model_latency = 3;
        pushExpect(2'b01, 32'd20, 1'b0);
        pushExpect(2'b10, 32'd9,  1'b0);
        pushExpect(2'b01, 32'd1,  1'b0);
        pushExpect(2'b10, 32'd10, 1'b0);
        fork
            begin
                applyStimulus(0, 5'b10010, 32'd100, 32'd5, 1'b1);
                applyStimulus(0, 5'b10100, 32'd50, 32'd7, 1'b1);
            end
            begin
                applyStimulus(1, 5'b10010, 32'd81, 32'd9, 1'b1);
                applyStimulus(1, 5'b10100, 32'd1000, 32'd33, 1'b1);
            end
        join
        waitDrain("t2");

        $display("[TB] divider timeout");
        model_latency = 0;
        pushExpect(2'b01, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(0, 5'b10010, 32'd1234, 32'd2, 1'b1);
        n = 0;
        while (rsp_valid_o == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_cycles", n, 32'd65);
        waitDrain("t3");
        model_latency = 4;
        pushExpect(2'b10, 32'd14, 1'b0);
        applyStimulus(1, 5'b10010, 32'd100, 32'd7, 1'b1);
        waitDrain("t3b");

        $display("[TB] response back-pressure");
        model_latency = 3;
        rsp_ready_i = 2'b00;
        pushExpect(2'b01, 32'd7, 1'b0);
        applyStimulus(0, 5'b10010, 32'd42, 32'd6, 1'b1);
        n = 0;
        while (rsp_valid_o == 2'b00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4_rsp_seen", {30'd0, rsp_valid_o}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            rsp_ready_i  = (i < 3) ? 2'b00 : 2'b10;
            req1_valid_i = 1'b1; req1_funct_i = 5'b10010; req1_op1_i = 32'd8; req1_op2_i = 32'd2;
            extra_done   = (i == 1 || i == 3);
            @(negedge clk);
            checkOutput("hold_valid", {30'd0, rsp_valid_o}, 32'd1);
            checkOutput("hold_data", rsp_data_o, 32'd7);
            checkOutput("hold_err", {31'd0, rsp_err_o}, 32'd0);
            checkOutput("hold_req_ready", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
        end
        @(posedge clk); #1;
        extra_done   = 1'b0;
        req1_valid_i = 1'b0;
        rsp_ready_i  = 2'b11;
        waitDrain("t4");

        $display("[TB] reset during wait");
        model_latency = 0;
        applyStimulus(0, 5'b10010, 32'd77, 32'd7, 1'b1);
        repeat (5) @(negedge clk);
        #2 Reset = 1'b1;
        req0_valid_i = 1'b1;
        #1 checkResetOutputs();
        repeat (2) @(posedge clk);
        #3;
        req0_valid_i = 1'b0;
        Reset = 1'b0;
        model_latency = 5;
        pushExpect(2'b10, 32'd9, 1'b0);
        applyStimulus(1, 5'b10100, 32'd297, 32'd16, 1'b1);
        waitDrain("t5");

        repeat (3) @(negedge clk);
        checkOutput("final_idle", {31'd0, busy_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
